// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
//
// Single-outstanding APB master. A command accepted on the cmd_* handshake
// runs one APB transfer (SETUP then ACCESS). The result is then held on
// rsp_* until the consumer takes it. All APB request outputs and all
// handshake outputs are driven directly from flops.
//
// Parameters
//   ADDR_W       APB address width
//   DATA_W       APB data width
//   TIMEOUT_CYC  ACCESS wait-cycle limit (only with APB_MASTER_TIMEOUT_EN)
//
// Optional feature
//   `define APB_MASTER_TIMEOUT_EN builds an ACCESS wait-cycle counter. Once
//   TIMEOUT_CYC enabled edges have passed with PREADY low, the transfer ends
//   with rsp_err=1 and rsp_rdata=0. If the macro is left undefined, ACCESS
//   waits for PREADY with no limit.
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   PCLKEN                   APB clock enable; SETUP->ACCESS->RESP only on it
//   cmd_valid/cmd_ready      command handshake
//   cmd_write/addr/wdata     command payload
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata/rsp_err        response payload (rdata is 0 for writes)
//   PADDR/PWDATA/PWRITE      APB request payload
//   PSEL/PENABLE             APB phase signals
//   PRDATA/PREADY/PSLVERR    APB completer response
// ---------------------------------------------------------------------------
module apb_master #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PCLKEN,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,

    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    output logic              PWRITE,
    output logic              PSEL,
    output logic              PENABLE,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e              state_q,     state_d;
    logic [ADDR_W-1:0]   paddr_q,     paddr_d;
    logic [DATA_W-1:0]   pwdata_q,    pwdata_d;
    logic                pwrite_q,    pwrite_d;
    logic                psel_q,      psel_d;
    logic                penable_q,   penable_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q,   rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
    // Enough bits to hold TIMEOUT_CYC itself.
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0]    tmo_cnt_q,   tmo_cnt_d;
    logic                tmo_hit_c;

    // This wait edge is the TIMEOUT_CYC-th one.
    assign tmo_hit_c = (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    // TIMEOUT_CYC is not used in this build.
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^32'(TIMEOUT_CYC);
`endif

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    // Next state, payload capture and registered output decode
    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                // cmd_ready is high throughout IDLE, so cmd_valid is the handshake
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    pwrite_d = cmd_write;
                    state_d  = SETUP;
`ifdef APB_MASTER_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end

            SETUP: begin
                if (PCLKEN) begin
                    state_d = ACCESS;
                end
            end

            ACCESS: begin
                if (PCLKEN) begin
                    if (PREADY) begin
                        rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                        rsp_err_d   = PSLVERR;
                        state_d     = RESP;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else begin
                        tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                        if (tmo_hit_c) begin
                            rsp_rdata_d = '0;
                            rsp_err_d   = 1'b1;
                            state_d     = RESP;
                        end
                    end
`endif
                end
            end

            RESP: begin
                // Returning to IDLE rather than taking a new command here
                // gives the next command at least one idle cycle.
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Decode from the next state so these outputs come straight from flops
        psel_d      = (state_d == SETUP) || (state_d == ACCESS);
        penable_d   = (state_d == ACCESS);
        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PWRITE    = pwrite_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;

endmodule

// File: tb/tb_apb_master.sv
// ---------------------------------------------------------------------------
// tb_apb_master
//
// Directed bench for apb_master. It includes a small memory completer with a
// programmable number of wait states and a programmable PSLVERR. Stimulus
// pushes the expected response into a queue. A separate monitor pops the
// queue on every rsp handshake and compares. Phase timing and APB stability
// are checked inline by the stimulus process.
// ---------------------------------------------------------------------------
module tb_apb_master;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              PCLKEN = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic              PWRITE;
    logic              PSEL;
    logic              PENABLE;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    apb_master #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (16)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .PCLKEN    (PCLKEN),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PWRITE    (PWRITE),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 CLK = ~CLK;

    // ---------------- memory completer ----------------
    logic [31:0] mem [0:63];
    int          wait_states = 0;
    logic        slverr_en   = 1'b0;
    int          acc_cnt     = 0;

    assign PREADY  = (acc_cnt >= wait_states);
    assign PSLVERR = PREADY & slverr_en;
    assign PRDATA  = mem[PADDR[7:2]];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    end

    always @(posedge CLK) begin
        if (PSEL && PENABLE) begin
            if (PCLKEN && !PREADY) acc_cnt <= acc_cnt + 1;
            if (PCLKEN && PREADY && PWRITE) mem[PADDR[7:2]] <= PWDATA;
        end else begin
            acc_cnt <= 0;
        end
    end

    // ---------------- checking ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Scoreboard monitor: compare on every response handshake
    always @(negedge CLK) begin
        exp_t e;
        if (!RST && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got rdata 0x%08h err %0d with nothing expected",
                         rsp_rdata, rsp_err);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic pclk_toggle = 1'b0;

    // One cycle: inputs change and outputs are read 1 time unit after the edge
    task automatic step();
        @(posedge CLK);
        #1;
        PCLKEN = pclk_toggle ? !PCLKEN : 1'b1;
    endtask

    task automatic issue(input logic wr, input logic [11:0] a, input logic [31:0] d);
        int n;
        n = 0;
        while (!cmd_ready && n < 200) begin
            step();
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_ready_timeout: got cmd_ready 0 after %0d cycles, required 1", n);
        end
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        step();
        cmd_valid = 1'b0;
    endtask

    // Runs one transfer and returns when rsp_valid is first seen.
    // lat counts cycles after the handshake (SETUP cycle = 1).
    task automatic run_xfer(input logic wr, input logic [11:0] a, input logic [31:0] d,
                            input logic [31:0] exp_rd, input logic exp_err,
                            output int lat, output int ps, output int pe,
                            output int bad, output int adv, output int viol);
        logic [2:0] ph, ph_prev;
        logic       pc_prev;
        exp_t       e;
        e.rdata = exp_rd;
        e.err   = exp_err;
        exp_q.push_back(e);
        issue(wr, a, d);
        lat = 0; ps = 0; pe = 0; bad = 0; adv = 0; viol = 0;
        ph_prev = 3'b000;
        pc_prev = 1'b1;
        while (lat < 200) begin
            lat++;
            ph = {rsp_valid, PENABLE, PSEL};
            if (lat > 1 && ph != ph_prev) begin
                adv++;
                if (!pc_prev) viol++;
            end
            if (PSEL) begin
                ps++;
                if (PENABLE) pe++;
                if (PADDR !== a || PWRITE !== wr || PWDATA !== d) bad++;
            end
            if (cmd_ready) bad++;
            if (rsp_valid) break;
            ph_prev = ph;
            pc_prev = PCLKEN;
            step();
        end
        if (!rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: got rsp_valid 0 after %0d cycles, required 1", lat);
        end
    endtask

    int   lat, ps, pe, bad, adv, viol, n;
    exp_t e_tmp;

    initial begin
        // Reset values
        RST = 1'b1;
        repeat (3) step();
        chk("rst_psel",      32'(PSEL),      0);
        chk("rst_penable",   32'(PENABLE),   0);
        chk("rst_pwrite",    32'(PWRITE),    0);
        chk("rst_paddr",     32'(PADDR),     0);
        chk("rst_pwdata",    PWDATA,         0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_rdata", rsp_rdata,      0);
        chk("rst_rsp_err",   32'(rsp_err),   0);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        RST = 1'b0;
        step();

        // Zero-wait write: 2 PSEL cycles, 1 PENABLE cycle, rsp 3 cycles after the handshake
        run_xfer(1'b1, 12'h010, 32'hA5A5_0001, 32'h0, 1'b0, lat, ps, pe, bad, adv, viol);
        chk("wr_latency", 32'(lat), 3);
        chk("wr_psel_cycles", 32'(ps), 2);
        chk("wr_penable_cycles", 32'(pe), 1);
        chk("wr_apb_stable", 32'(bad), 0);
        step();

        // Zero-wait read-back
        run_xfer(1'b0, 12'h010, 32'h0, 32'hA5A5_0001, 1'b0, lat, ps, pe, bad, adv, viol);
        chk("rd_latency", 32'(lat), 3);
        chk("rd_penable_cycles", 32'(pe), 1);
        chk("rd_apb_stable", 32'(bad), 0);
        step();

        // Three wait states, PSLVERR on completion
        wait_states = 3;
        slverr_en   = 1'b1;
        run_xfer(1'b1, 12'h024, 32'hDEAD_BEEF, 32'h0, 1'b1, lat, ps, pe, bad, adv, viol);
        chk("ws3_access_cycles", 32'(pe), 4);
        chk("ws3_latency", 32'(lat), 6);
        chk("ws3_apb_stable", 32'(bad), 0);
        step();

        // Read with wait states and error still returns PRDATA
        wait_states = 2;
        run_xfer(1'b0, 12'h010, 32'h0, 32'hA5A5_0001, 1'b1, lat, ps, pe, bad, adv, viol);
        chk("ws2_access_cycles", 32'(pe), 3);
        chk("ws2_apb_stable", 32'(bad), 0);
        wait_states = 0;
        slverr_en   = 1'b0;
        step();

        // PCLKEN toggling 1,0,1,0: phase advances only on PCLKEN=1 edges
        pclk_toggle = 1'b1;
        run_xfer(1'b1, 12'h030, 32'h1234_5678, 32'h0, 1'b0, lat, ps, pe, bad, adv, viol);
        chk("tog_wr_advances", 32'(adv), 2);
        chk("tog_wr_bad_edges", 32'(viol), 0);
        chk("tog_wr_apb_stable", 32'(bad), 0);
        step();
        run_xfer(1'b0, 12'h030, 32'h0, 32'h1234_5678, 1'b0, lat, ps, pe, bad, adv, viol);
        chk("tog_rd_advances", 32'(adv), 2);
        chk("tog_rd_bad_edges", 32'(viol), 0);
        pclk_toggle = 1'b0;
        step();

        // Response backpressure with a command already waiting
        rsp_ready = 1'b0;
        run_xfer(1'b0, 12'h030, 32'h0, 32'h1234_5678, 1'b0, lat, ps, pe, bad, adv, viol);
        e_tmp.rdata = 32'hDEAD_BEEF;
        e_tmp.err   = 1'b0;
        exp_q.push_back(e_tmp);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 12'h024;
        cmd_wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_rsp_valid", 32'(rsp_valid), 1);
            chk("bp_rsp_rdata", rsp_rdata, 32'h1234_5678);
            chk("bp_cmd_ready", 32'(cmd_ready), 0);
        end
        rsp_ready = 1'b1;
        step();
        chk("post_rsp_cmd_ready", 32'(cmd_ready), 1);
        chk("post_rsp_psel", 32'(PSEL), 0);
        chk("post_rsp_valid", 32'(rsp_valid), 0);
        step();
        chk("next_cmd_psel", 32'(PSEL), 1);
        chk("next_cmd_paddr", 32'(PADDR), 32'h024);
        cmd_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        chk("bp_drained", 32'(exp_q.size()), 0);
        step();

`ifdef APB_MASTER_TIMEOUT_EN
        // PREADY stuck low: error response after 16 wait cycles
        wait_states = 1000;
        run_xfer(1'b0, 12'h010, 32'h0, 32'h0, 1'b1, lat, ps, pe, bad, adv, viol);
        chk("tmo_access_cycles", 32'(pe), 16);
        chk("tmo_latency", 32'(lat), 18);
        wait_states = 0;
        step();
`endif

        // Reset in ACCESS aborts the transfer (no response is expected)
        wait_states = 1000;
        issue(1'b0, 12'h010, 32'h0);
        repeat (4) step();
        chk("abort_in_access", 32'({PSEL, PENABLE}), 32'h3);
`ifndef APB_MASTER_TIMEOUT_EN
        repeat (40) step();
        chk("no_tmo_still_access", 32'({PSEL, PENABLE, rsp_valid}), 32'h6);
`endif
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("abort_psel", 32'(PSEL), 0);
        chk("abort_penable", 32'(PENABLE), 0);
        chk("abort_rsp_valid", 32'(rsp_valid), 0);
        chk("abort_cmd_ready", 32'(cmd_ready), 1);
        chk("abort_paddr", 32'(PADDR), 0);
        wait_states = 0;
        repeat (3) step();
        chk("abort_no_rsp", 32'(rsp_valid), 0);

        // Normal operation resumes
        run_xfer(1'b0, 12'h010, 32'h0, 32'hA5A5_0001, 1'b0, lat, ps, pe, bad, adv, viol);
        chk("resume_latency", 32'(lat), 3);
        step();
        step();
        chk("final_queue_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
